// File: rtl/csa_multi_adder_pipe.sv
// Multi-operand adder: carry-save 3:2 reduction in S1, carry-propagate add with wrap/saturate in S2.
// Latency: 2 cycles from input accept to out_valid; one beat per cycle when not stalled.
// Backpressure: out_ready low holds the output stage; in_ready drops once both stages are occupied.
module csa_multi_adder_pipe #(
    parameter int WIDTH  = 4,
    parameter int NUM_IN = 3,
    parameter int FULL_W = WIDTH + $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic                    in_signed,
    input  logic                    in_sat,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_sum,
    output logic [FULL_W-1:0]       out_full,
    output logic                    out_ovf
);
    localparam int EXT_W = FULL_W - WIDTH;

    logic [FULL_W-1:0] ext_op [NUM_IN];
    logic [FULL_W-1:0] csa_sum;
    logic [FULL_W-1:0] csa_carry;
    logic [FULL_W-1:0] prev_sum;

    logic              s1_valid;
    logic [FULL_W-1:0] s1_sum;
    logic [FULL_W-1:0] s1_carry;
    logic              s1_signed;
    logic              s1_sat;

    logic              s1_load;
    logic              s2_load;
    logic              accept;

    logic [FULL_W-1:0] full;
    logic              ovf_nxt;
    logic [WIDTH-1:0]  sum_nxt;

    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;
    assign accept   = in_valid && in_ready;

    always_comb begin
        for (int k = 0; k < NUM_IN; k++) begin
            ext_op[k] = {{EXT_W{in_signed & in_data[k*WIDTH+WIDTH-1]}}, in_data[k*WIDTH +: WIDTH]};
        end
    end

    // Each 3:2 compressor folds one more operand into the redundant (sum, carry) pair;
    // with two operands the pair is just the operands themselves.
    always_comb begin
        csa_sum   = ext_op[0];
        csa_carry = ext_op[1];
        prev_sum  = '0;
        for (int k = 2; k < NUM_IN; k++) begin
            prev_sum  = csa_sum;
            csa_sum   = prev_sum ^ csa_carry ^ ext_op[k];
            csa_carry = ((prev_sum & csa_carry) | (prev_sum & ext_op[k]) | (csa_carry & ext_op[k])) << 1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_sum    <= '0;
            s1_carry  <= '0;
            s1_signed <= 1'b0;
            s1_sat    <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sum    <= csa_sum;
                s1_carry  <= csa_carry;
                s1_signed <= in_signed;
                s1_sat    <= in_sat;
            end
        end
    end

    assign full = s1_sum + s1_carry;

    // Signed results fit only when every bit from the WIDTH-1 sign position upward agrees.
    always_comb begin
        if (s1_signed) begin
            ovf_nxt = !((&full[FULL_W-1:WIDTH-1]) || !(|full[FULL_W-1:WIDTH-1]));
        end else begin
            ovf_nxt = |full[FULL_W-1:WIDTH];
        end
        sum_nxt = full[WIDTH-1:0];
        if (ovf_nxt && s1_sat) begin
            if (!s1_signed) begin
                sum_nxt = '1;
            end else if (full[FULL_W-1]) begin
                sum_nxt = {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
                sum_nxt = {1'b0, {(WIDTH-1){1'b1}}};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_full  <= '0;
            out_ovf   <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sum  <= sum_nxt;
                out_full <= full;
                out_ovf  <= ovf_nxt;
            end
        end
    end

endmodule
